// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared definitions for the fetch-side stall controller: FSM encoding,
// reset defaults and the width of the consecutive-stall run counter.
package fetch_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  // Run counter is narrow on purpose: it only has to reach STALL_LIMIT (<= 255).
  localparam int                   RUN_CNT_W   = 8;
  localparam logic [RUN_CNT_W-1:0] RUN_CNT_MAX = '1;

endpackage

// File: rtl/fetch_stall_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Inc,
  output logic [W-1:0] Count
);

  logic [W-1:0] r_count;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_count <= '0;
    end else if (Inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign Count = r_count;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch-side consumer of the hazard unit: owns PC and IF/ID, applies ID-stage
// redirects with a one-slot flush, and tracks stalls, flushes and misuse.
module fetch_stall_ctrl
  import fetch_stall_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR   = DEF_NOP_INSTR,
  parameter int          STALL_LIMIT = 16,
  parameter int          CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             PCWrite,
  input  logic             IFIDWrite,
  input  logic             ControlWrite,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  input  logic [31:0]      InstrIn,
  output logic [31:0]      PCOut,
  output logic [31:0]      IFIDInstr,
  output logic [31:0]      IFIDPCPlus4,
  output logic             IFIDValid,
  output logic             IDEXBubble,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             StallTimeout,
  output logic             ProtocolErr
);

  localparam logic [RUN_CNT_W-1:0] LIMIT = RUN_CNT_W'(STALL_LIMIT);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_in_flush;
  logic [31:0]            r_pc;
  logic [31:0]            r_ifid_instr;
  logic [31:0]            r_ifid_pc4;
  logic                   r_ifid_valid;
  logic [RUN_CNT_W-1:0]   r_run_cnt;
  logic [RUN_CNT_W-1:0]   w_run_inc;
  logic                   r_timeout;
  logic                   r_perr;
  logic                   w_redirect;
  logic [31:0]            w_target;
  logic [31:0]            w_pc_plus4;
  logic                   w_ifid_load;

  // A redirect while stalled is dropped; ID re-presents it after the release.
  assign w_redirect = PCWrite & (Jump | BranchTaken);
  assign w_target   = Jump ? JumpTarget : BranchTarget;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_run_inc  = (r_run_cnt == RUN_CNT_MAX) ? r_run_cnt : r_run_cnt + 1'b1;
  // The flush bubble must survive a stall that lands right after the redirect.
  assign w_ifid_load = IFIDWrite & ~(w_in_flush & ~PCWrite);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = ST_RUN;
    if (w_redirect) begin
      w_state_next = ST_FLUSH;
    end else if (!PCWrite) begin
      w_state_next = ST_STALL;
    end
  end

  always_comb begin
    w_in_flush = (r_state == ST_FLUSH);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pc         <= RESET_PC;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else if (w_redirect) begin
      r_pc         <= w_target;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else begin
      if (PCWrite) begin
        r_pc <= w_pc_plus4;
      end
      if (w_ifid_load) begin
        r_ifid_instr <= InstrIn;
        r_ifid_pc4   <= w_pc_plus4;
        r_ifid_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_run_cnt <= '0;
      r_timeout <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      if (PCWrite) begin
        r_run_cnt <= '0;
      end else begin
        r_run_cnt <= w_run_inc;
        if (w_run_inc >= LIMIT) begin
          r_timeout <= 1'b1;
        end
      end
      if (PCWrite != IFIDWrite) begin
        r_perr <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .Inc   (~PCWrite),
    .Count (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .Inc   (w_redirect),
    .Count (FlushCount)
  );

  assign PCOut        = r_pc;
  assign IFIDInstr    = r_ifid_instr;
  assign IFIDPCPlus4  = r_ifid_pc4;
  assign IFIDValid    = r_ifid_valid;
  assign IDEXBubble   = ~ControlWrite | ~r_ifid_valid;
  assign StallTimeout = r_timeout;
  assign ProtocolErr  = r_perr;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed scenarios plus randomized traffic, checked against a cycle-level
// behavioural model of the fetch/stall rules.
module tb_fetch_stall_ctrl;

  localparam int LIMIT = 16;

  logic        clk = 1'b0;
  logic        rst, pcw, ifw, cw, bt, jmp;
  logic [31:0] btgt, jtgt, instr;
  logic [31:0] pc_out, ifid_instr, ifid_pc4, stall_cnt, flush_cnt;
  logic        ifid_valid, bubble, timeout, perr;

  int n_checks = 0;
  int n_pass   = 0;

  // reference state
  logic [31:0] m_pc, m_instr, m_pc4, m_stall, m_flush;
  logic        m_valid, m_to, m_perr, m_after_redirect;
  int          m_run;

  always #5 clk = ~clk;

  fetch_stall_ctrl #(
    .RESET_PC    (32'h0),
    .NOP_INSTR   (32'h0),
    .STALL_LIMIT (LIMIT),
    .CNT_W       (32)
  ) dut (
    .Clk          (clk),
    .Rst          (rst),
    .PCWrite      (pcw),
    .IFIDWrite    (ifw),
    .ControlWrite (cw),
    .BranchTaken  (bt),
    .BranchTarget (btgt),
    .Jump         (jmp),
    .JumpTarget   (jtgt),
    .InstrIn      (instr),
    .PCOut        (pc_out),
    .IFIDInstr    (ifid_instr),
    .IFIDPCPlus4  (ifid_pc4),
    .IFIDValid    (ifid_valid),
    .IDEXBubble   (bubble),
    .StallCount   (stall_cnt),
    .FlushCount   (flush_cnt),
    .StallTimeout (timeout),
    .ProtocolErr  (perr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},     pc_out,     m_pc);
    chk({tag, ".instr"},  ifid_instr, m_instr);
    chk({tag, ".pc4"},    ifid_pc4,   m_pc4);
    chk({tag, ".valid"},  {31'd0, ifid_valid}, {31'd0, m_valid});
    chk({tag, ".stalls"}, stall_cnt,  m_stall);
    chk({tag, ".flushes"}, flush_cnt, m_flush);
    chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, m_to});
    chk({tag, ".perr"},   {31'd0, perr}, {31'd0, m_perr});
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
    m_stall = 0; m_flush = 0; m_to = 0; m_perr = 0;
    m_run = 0; m_after_redirect = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_all(tag);
    $display("txn %s: reset pc=%h", tag, pc_out);
  endtask

  // one clock of stimulus; model applies the rules in priority order
  task automatic step(input string tag, input logic p, input logic f, input logic c,
                      input logic b, input logic [31:0] bta, input logic j,
                      input logic [31:0] jta, input logic [31:0] ins);
    logic [31:0] old_pc;
    pcw = p; ifw = f; cw = c; bt = b; btgt = bta; jmp = j; jtgt = jta; instr = ins;
    #1;
    chk({tag, ".bubble"}, {31'd0, bubble}, {31'd0, (~c | ~m_valid)});
    old_pc = m_pc;
    if (p != f) m_perr = 1;
    if (p && (j || b)) begin
      m_pc = j ? jta : bta;
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      if (m_flush != 32'hFFFF_FFFF) m_flush++;
      m_run = 0;
      m_after_redirect = 1;
    end else begin
      if (!p) begin
        if (m_stall != 32'hFFFF_FFFF) m_stall++;
        if (m_run < 255) m_run++;
        if (m_run >= LIMIT) m_to = 1;
      end else begin
        m_run = 0;
      end
      if (f && !(m_after_redirect && !p)) begin
        m_instr = ins; m_pc4 = old_pc + 4; m_valid = 1;
      end
      if (p) m_pc = old_pc + 4;
      m_after_redirect = 0;
    end
    @(posedge clk); #1;
    check_all(tag);
    $display("txn %s: pcw=%0b ifw=%0b bt=%0b j=%0b -> pc=%h instr=%h v=%0b st=%0d fl=%0d to=%0b pe=%0b",
             tag, p, f, b, j, pc_out, ifid_instr, ifid_valid, stall_cnt, flush_cnt, timeout, perr);
  endtask

  task automatic adv(input string tag, input logic [31:0] ins);
    step(tag, 1, 1, 1, 0, 0, 0, 0, ins);
  endtask

  task automatic stall(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
  endtask

  initial begin
    rst = 0; pcw = 1; ifw = 1; cw = 1; bt = 0; jmp = 0; btgt = 0; jtgt = 0; instr = 0;
    model_reset();
    @(negedge clk);
    do_reset("reset");
    chk("reset.pc_const", pc_out, 32'h0);

    for (int i = 0; i < 4; i++) adv("free", 32'h2008_0001);
    chk("free.pc16", pc_out, 32'h10);
    chk("free.instr", ifid_instr, 32'h2008_0001);

    // load-use stall at 0x10
    pcw = 0; ifw = 0; cw = 0; #1;
    chk("loaduse.bubble_const", {31'd0, bubble}, 32'd1);
    stall("loaduse");
    chk("loaduse.pc_hold", pc_out, 32'h10);
    chk("loaduse.stalls1", stall_cnt, 32'd1);
    adv("resume", 32'h0000_0020);
    chk("resume.pc", pc_out, 32'h14);
    adv("adv", 32'h1);
    adv("adv", 32'h2);

    // branch then branch+jump
    step("branch", 1, 1, 1, 1, 32'h40, 0, 0, 32'h3);
    chk("branch.pc", pc_out, 32'h40);
    chk("branch.flush1", flush_cnt, 32'd1);
    step("jump_wins", 1, 1, 1, 1, 32'h40, 1, 32'h80, 32'h4);
    chk("jump_wins.pc", pc_out, 32'h80);

    // redirect during a stall is ignored (also stall right after FLUSH)
    step("br_stalled", 0, 0, 0, 1, 32'hC0, 0, 0, 32'h5);
    chk("br_stalled.pc", pc_out, 32'h80);
    chk("br_stalled.valid", {31'd0, ifid_valid}, 32'd0);
    step("br_release", 1, 1, 1, 1, 32'hC0, 0, 0, 32'h6);
    chk("br_release.pc", pc_out, 32'hC0);
    chk("br_release.flush3", flush_cnt, 32'd3);

    // watchdog
    adv("adv", 32'h7);
    for (int i = 1; i <= LIMIT; i++) begin
      stall("wd");
      if (i == LIMIT - 1) chk("wd.not_yet", {31'd0, timeout}, 32'd0);
    end
    chk("wd.trip", {31'd0, timeout}, 32'd1);
    adv("wd_release", 32'h8);
    chk("wd.sticky", {31'd0, timeout}, 32'd1);
    do_reset("wd_reset");

    // protocol error, then reset mid-stall
    adv("adv", 32'h9);
    step("perr", 1, 0, 1, 0, 0, 0, 0, 32'hA);
    chk("perr.flag", {31'd0, perr}, 32'd1);
    chk("perr.pc", pc_out, 32'h8);
    chk("perr.ifid_hold", ifid_instr, 32'h9);
    stall("pre_rst");
    stall("pre_rst");
    do_reset("mid_stall_reset");

    // PC wrap
    step("to_top", 1, 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'hB);
    adv("wrap", 32'hC);
    chk("wrap.pc", pc_out, 32'h0);
    chk("wrap.pc4", ifid_pc4, 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic p, f, b, j;
      logic [31:0] bta, jta;
      p = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 19) == 0) ? ~p : p;
      b = ($urandom_range(0, 7) == 0);
      j = ($urandom_range(0, 9) == 0);
      bta = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      jta = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      step("rand", p, f, $urandom_range(0, 1) == 1, b, bta, j, jta, $urandom());
      if (i == 200) do_reset("rand_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
